// File: rtl/alu_pipe_flow_demo.sv
// ---------------------------------------------------------------------------
// alu_pipe_flow_demo
//
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 registers the operands and opcode. Stage 2 computes the result
// from the stage-1 registers and registers y/cout. The output side can stall
// the pipeline: each stage advances only when its downstream slot is free
// or is emptying this cycle. A wrapping counter tracks output handshakes.
//
// Optional build macro: ALU_PIPE_FLAGS_EN
//   When defined, adds registered zero/ovf status outputs in stage 2.
//
// Parameters:
//   WIDTH       operand/result width (>= 2)
//   CNT_W       width of done_count
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       synchronous active-low reset
//   in_valid    operand beat present
//   in_ready    block can accept a beat this cycle (combinational)
//   a, b        operands
//   op          opcode (AND,NAND,OR,NOR,XOR,ADD,SUB,SHL)
//   out_valid   result beat present
//   out_ready   consumer accepts the result this cycle
//   y, cout     result and carry/borrow/shift-out
//   done_count  output handshakes since reset, wrapping
//   zero, ovf   (ALU_PIPE_FLAGS_EN only) result-is-zero, signed overflow
// ---------------------------------------------------------------------------
module alu_pipe_flow_demo #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
`ifdef ALU_PIPE_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic [CNT_W-1:0] done_count
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;

  // Stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s2_adv;
  logic s1_adv;
  logic out_hs;

  // Combinational ALU on stage-1 contents
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  // A slot may take new data when it is empty or its occupant leaves now.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = s2_valid_q && out_ready;

  assign add_full = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  // a - b as a + ~b + 1; the top bit is the "no borrow" carry.
  assign sub_full = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    case (s1_op_q)
      OP_AND:  alu_y = s1_a_q & s1_b_q;
      OP_NAND: alu_y = ~(s1_a_q & s1_b_q);
      OP_OR:   alu_y = s1_a_q | s1_b_q;
      OP_NOR:  alu_y = ~(s1_a_q | s1_b_q);
      OP_XOR:  alu_y = s1_a_q ^ s1_b_q;
      OP_ADD: begin
        alu_y = add_full[WIDTH-1:0];
        alu_c = add_full[WIDTH];
      end
      OP_SUB: begin
        alu_y = sub_full[WIDTH-1:0];
        alu_c = sub_full[WIDTH];
      end
      OP_SHL: begin
        alu_y = {s1_a_q[WIDTH-2:0], 1'b0};
        alu_c = s1_a_q[WIDTH-1];
      end
      default: begin
        alu_y = '0;
        alu_c = 1'b0;
      end
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic alu_zero;
  logic alu_ovf;
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;

  // Overflow: both adder inputs share a sign and the sum's sign differs.
  // For SUB the second adder input is ~b.
  always_comb begin
    alu_zero = (alu_y == '0);
    alu_ovf  = 1'b0;
    case (s1_op_q)
      OP_ADD: alu_ovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                        (alu_y[WIDTH-1] != s1_a_q[WIDTH-1]);
      OP_SUB: alu_ovf = (s1_a_q[WIDTH-1] == ~s1_b_q[WIDTH-1]) &&
                        (alu_y[WIDTH-1] != s1_a_q[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  // Next-state logic. Data registers load only alongside a valid beat so the
  // outputs hold their last result while the pipeline is idle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    cout_d     = cout_q;
    cnt_d      = cnt_q;
`ifdef ALU_PIPE_FLAGS_EN
    zero_d     = zero_q;
    ovf_d      = ovf_q;
`endif

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = a;
        s1_b_d  = b;
        s1_op_d = op;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d    = alu_y;
        cout_d = alu_c;
`ifdef ALU_PIPE_FLAGS_EN
        zero_d = alu_zero;
        ovf_d  = alu_ovf;
`endif
      end
    end

    if (out_hs) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      cout_q     <= 1'b0;
      cnt_q      <= '0;
`ifdef ALU_PIPE_FLAGS_EN
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      cout_q     <= cout_d;
      cnt_q      <= cnt_d;
`ifdef ALU_PIPE_FLAGS_EN
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign out_valid  = s2_valid_q;
  assign y          = y_q;
  assign cout       = cout_q;
  assign done_count = cnt_q;
`ifdef ALU_PIPE_FLAGS_EN
  assign zero       = zero_q;
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_alu_pipe_flow_demo.sv
// ---------------------------------------------------------------------------
// Bench for alu_pipe_flow_demo (WIDTH=8, CNT_W=16).
// A queue-based model tracks beats in flight; a negedge process compares the
// DUT against it every cycle. Directed tests add hand-computed expectations.
// Define ALU_PIPE_FLAGS_EN to also exercise zero/ovf.
// ---------------------------------------------------------------------------
module tb_alu_pipe_flow_demo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic       cout;
  logic [15:0] done_count;
`ifdef ALU_PIPE_FLAGS_EN
  logic       zero;
  logic       ovf;
`endif

  alu_pipe_flow_demo #(.WIDTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
`ifdef ALU_PIPE_FLAGS_EN
    .zero      (zero),
    .ovf       (ovf),
`endif
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] y;
    logic       c;
    logic       z;
    logic       v;
    int         acc;   // cycle index in which the beat was accepted
  } ent_t;

  function automatic ent_t alu_model(input int ia, input int ib, input int iop);
    ent_t e;
    int r, sa, sb;
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    r = 0; e.c = 1'b0; e.v = 1'b0; e.acc = 0;
    case (iop)
      0: r = ia & ib;
      1: r = (~(ia & ib)) & 255;
      2: r = ia | ib;
      3: r = (~(ia | ib)) & 255;
      4: r = ia ^ ib;
      5: begin r = ia + ib; e.c = (r > 255); e.v = (sa + sb > 127) || (sa + sb < -128); end
      6: begin r = ia - ib; e.c = (ia >= ib); e.v = (sa - sb > 127) || (sa - sb < -128); end
      default: begin r = ia * 2; e.c = (ia >= 128); end
    endcase
    e.y = r[7:0];
    e.z = (e.y == 8'h00);
    return e;
  endfunction

  ent_t       q[$];
  ent_t       last;
  int         cyc = 0;
  logic [15:0] m_cnt = '0;
  bit         live = 0;

  // A beat accepted in cycle c is presented during cycle c+2 at the earliest
  // and leaves in order. Capacity is two beats, so input is refused only
  // when two beats are held and the consumer is not taking one.
  function automatic bit m_out_valid();
    return (q.size() > 0) && (cyc >= q[0].acc + 2);
  endfunction

  function automatic bit m_in_ready();
    return (q.size() < 2) || out_ready;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      last = '{y: 8'h00, c: 1'b0, z: 1'b0, v: 1'b0, acc: 0};
      m_cnt = '0;
      live = 1;
    end else if (live) begin
      bit ov, ir;
      ov = m_out_valid();
      ir = m_in_ready();
      if (ov && out_ready) begin
        last = q.pop_front();
        m_cnt = m_cnt + 16'd1;
      end
      if (in_valid && ir) begin
        ent_t e;
        e = alu_model(int'(a), int'(b), int'(op));
        e.acc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (live) begin
      bit ov;
      ent_t e;
      ov = m_out_valid();
      e = ov ? q[0] : last;
      chk("out_valid", {31'b0, out_valid}, {31'b0, ov});
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_in_ready()});
      chk("done_count", {16'b0, done_count}, {16'b0, m_cnt});
      chk("y", {24'b0, y}, {24'b0, e.y});
      chk("cout", {31'b0, cout}, {31'b0, e.c});
`ifdef ALU_PIPE_FLAGS_EN
      chk("zero", {31'b0, zero}, {31'b0, e.z});
      chk("ovf", {31'b0, ovf}, {31'b0, e.v});
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] cap_y;
  logic       cap_c;
  logic       cap_z;
  logic       cap_v;
  int         cap_lat;

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Send one beat with out_ready high, capture the result and its latency
  // in cycles after the accept cycle.
  task automatic run_one(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top);
    bit acc;
    int k;
    in_valid = 1'b1; a = ta; b = tb; op = top; out_ready = 1'b1;
    acc = 0; k = 0;
    while (!acc && k < 20) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; k++;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    cap_lat = 0; cap_y = 'x; cap_c = 'x; cap_z = 'x; cap_v = 'x;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (out_valid) begin
        cap_lat = j; cap_y = y; cap_c = cout;
`ifdef ALU_PIPE_FLAGS_EN
        cap_z = zero; cap_v = ovf;
`endif
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct { logic [2:0] o; logic [7:0] ey; logic ec; } sweep_t;
  sweep_t sweep[8] = '{
    '{3'd0, 8'h20, 1'b0}, '{3'd1, 8'hDF, 1'b0}, '{3'd2, 8'hF0, 1'b0},
    '{3'd3, 8'h0F, 1'b0}, '{3'd4, 8'hD0, 1'b0}, '{3'd5, 8'h10, 1'b1},
    '{3'd6, 8'hD0, 1'b1}, '{3'd7, 8'hE0, 1'b1}
  };

  initial begin
    logic [7:0] got[$];
    int nxt;
    bit stall_seen;
    int accepts;
    int guard;

    // Reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_y", {24'b0, y}, 0);
    chk("rst_cout", {31'b0, cout}, 0);
    chk("rst_done", {16'b0, done_count}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;

    // Opcode sweep a=F0 b=20
    foreach (sweep[i]) begin
      run_one(8'hF0, 8'h20, sweep[i].o);
      chk("sweep_lat", cap_lat, 2);
      chk("sweep_y", {24'b0, cap_y}, {24'b0, sweep[i].ey});
      chk("sweep_cout", {31'b0, cap_c}, {31'b0, sweep[i].ec});
    end

    // SUB borrow / equal
    run_one(8'h05, 8'h07, 3'd6);
    chk("sub_borrow_y", {24'b0, cap_y}, 32'hFE);
    chk("sub_borrow_c", {31'b0, cap_c}, 0);
    run_one(8'h07, 8'h07, 3'd6);
    chk("sub_eq_y", {24'b0, cap_y}, 32'h00);
    chk("sub_eq_c", {31'b0, cap_c}, 1);

    // Backpressure: 5 ADD beats, out_ready low in cycles 3..6
    do_reset();
    nxt = 0; stall_seen = 0; got.delete();
    for (int t = 0; t < 30; t++) begin
      out_ready = !(t >= 3 && t <= 6);
      in_valid = (nxt < 5);
      a = nxt[7:0]; b = 8'h01; op = 3'd5;
      @(negedge clk);
      if (!in_ready) stall_seen = 1;
      if (t == 6) chk("bp_hold_y", {24'b0, y}, 32'h02);
      if (in_valid && in_ready) nxt++;
      if (out_valid && out_ready) got.push_back(y);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_stall_seen", {31'b0, stall_seen}, 1);
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk("bp_order", {24'b0, got[i]}, i + 1);
    @(negedge clk);
    chk("bp_done", {16'b0, done_count}, 5);
    @(posedge clk); #1;

    // Reset mid-flight: two beats held, then reset
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h01; b = 8'h01; op = 3'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", {31'b0, out_valid}, 0);
    chk("mr_done", {16'b0, done_count}, 0);
    chk("mr_y", {24'b0, y}, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mr_no_stale", {31'b0, out_valid}, 0);
      @(posedge clk); #1;
    end
    run_one(8'hAA, 8'h55, 3'd4);
    chk("mr_xor_lat", cap_lat, 2);
    chk("mr_xor_y", {24'b0, cap_y}, 32'hFF);

`ifdef ALU_PIPE_FLAGS_EN
    run_one(8'h7F, 8'h01, 3'd5);
    chk("flg_add_y", {24'b0, cap_y}, 32'h80);
    chk("flg_add_ovf", {31'b0, cap_v}, 1);
    chk("flg_add_zero", {31'b0, cap_z}, 0);
    run_one(8'h80, 8'h01, 3'd6);
    chk("flg_sub_y", {24'b0, cap_y}, 32'h7F);
    chk("flg_sub_ovf", {31'b0, cap_v}, 1);
    run_one(8'h0F, 8'hF0, 3'd0);
    chk("flg_and_zero", {31'b0, cap_z}, 1);
    chk("flg_and_ovf", {31'b0, cap_v}, 0);
`endif

    // Counter wrap: 65537 handshakes
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    accepts = 0; guard = 0;
    while (accepts < 65537 && guard < 70000) begin
      a = accepts[7:0]; b = accepts[15:8]; op = accepts[2:0];
      @(negedge clk);
      if (in_ready) accepts++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    chk("wrap_accepts", accepts, 65537);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wrap_done", {16'b0, done_count}, 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
